// File: rtl/tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_pkg
// Shared definitions for the 1-to-N time-division demultiplexer:
//   - FSM state encodings (IDLE / COLLECT / PARITY)
//   - default lane count and slot-index width derivation
//   - number of parity beats per frame (0, or 1 when parity is enabled)
// Configuration macro: DEMUX_PARITY_EN (adds a trailing even-parity beat).
// -----------------------------------------------------------------------------
package tdm_demux_pkg;

   localparam int DEFAULT_LANES = 4;

`ifdef DEMUX_PARITY_EN
   localparam int PARITY_BEATS = 1;
`else
   localparam int PARITY_BEATS = 0;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
`ifdef DEMUX_PARITY_EN
      COLLECT = 2'd1,
      PARITY  = 2'd2
`else
      COLLECT = 2'd1
`endif
   } state_e;

   // Slot index width; never narrower than one bit.
   function automatic int sel_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4_if
// Serial-in / parallel-out bus of the TDM demultiplexer.
//   In, in_valid, in_sof       : serial beat from the upstream 4:1 MUX
//   S                          : slot index of the next expected beat
//   Out, out_valid             : last complete word and its one-cycle strobe
//   frame_err, par_err         : one-cycle error pulses
// Modports: master = stream source / consumer side, slave = demultiplexer.
// -----------------------------------------------------------------------------
interface tdm_demux_1to4_if #(
   parameter int LANES = tdm_demux_pkg::DEFAULT_LANES
);
   localparam int SEL_W = tdm_demux_pkg::sel_w(LANES);

   logic             In;
   logic             in_valid;
   logic             in_sof;
   logic [SEL_W-1:0] S;
   logic [LANES-1:0] Out;
   logic             out_valid;
   logic             frame_err;
   logic             par_err;

   modport master (
      output In, in_valid, in_sof,
      input  S, Out, out_valid, frame_err, par_err
   );

   modport slave (
      input  In, in_valid, in_sof,
      output S, Out, out_valid, frame_err, par_err
   );

endinterface

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
// Owns the slot index S of the demultiplexer.
//   clk, rst : clock, synchronous active-high reset
//   load1    : start of frame (slot 0 consumed) -> S = 1
//   inc      : advance one slot; saturates at LANES-1
//   clr      : return to slot 0 (frame complete)
//   s        : current slot index
//   at_last  : s == LANES-1
// Priority: rst > clr > load1 > inc.
// -----------------------------------------------------------------------------
module tdm_slot_counter #(
   parameter int LANES = tdm_demux_pkg::DEFAULT_LANES,
   parameter int SEL_W = tdm_demux_pkg::sel_w(LANES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load1,
   input  logic             inc,
   input  logic             clr,
   output logic [SEL_W-1:0] s,
   output logic             at_last
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

   assign at_last = (s == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         s <= '0;
      end else if (clr) begin
         s <= '0;
      end else if (load1) begin
         s <= SEL_W'(1);
      end else if (inc && !at_last) begin
         // Wrapping happens only through clr, never by overflow.
         s <= s + 1'b1;
      end
   end

endmodule

// File: rtl/tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4
// Receive end of a 4:1 TDM stream: one serial bit per valid beat is steered
// into lane S, and the reassembled word is presented on a held output with a
// one-cycle out_valid strobe.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset, priority over any beat
//   bus  : tdm_demux_1to4_if.slave (In/in_valid/in_sof in; S, Out, out_valid,
//          frame_err, par_err out; all outputs registered)
// Configuration macro: DEMUX_PARITY_EN -- frame gets one extra even-parity
// beat and par_err becomes active; otherwise par_err is tied low.
// -----------------------------------------------------------------------------
module tdm_demux_1to4
   import tdm_demux_pkg::*;
#(
   parameter int LANES = DEFAULT_LANES
) (
   input  logic                    clk,
   input  logic                    rst,
   tdm_demux_1to4_if.slave         bus
);

   localparam int SEL_W = sel_w(LANES);

   state_e           state, state_nxt;
   logic [LANES-1:0] shadow, shadow_nxt;
   logic [LANES-1:0] out_q, out_nxt;
   logic             ov_q, ov_nxt;
   logic             fe_q, fe_nxt;
   logic [LANES-1:0] merged;
   logic [LANES-1:0] first_word;
   logic             cnt_load, cnt_inc, cnt_clr;
   logic [SEL_W-1:0] s;
   logic             at_last;
`ifdef DEMUX_PARITY_EN
   logic             pe_q, pe_nxt;
`endif

   tdm_slot_counter #(
      .LANES (LANES),
      .SEL_W (SEL_W)
   ) u_slot_counter (
      .clk     (clk),
      .rst     (rst),
      .load1   (cnt_load),
      .inc     (cnt_inc),
      .clr     (cnt_clr),
      .s       (s),
      .at_last (at_last)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      shadow_nxt = shadow;
      out_nxt    = out_q;
      ov_nxt     = 1'b0;
      fe_nxt     = 1'b0;
      cnt_load   = 1'b0;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;
`ifdef DEMUX_PARITY_EN
      pe_nxt     = 1'b0;
`endif
      // Slot 0 of a fresh frame; stale bits from an aborted frame are dropped.
      first_word = LANES'(bus.In);
      // Shadow with the current beat folded in, so the last data beat can
      // commit on the same edge it is sampled.
      merged     = shadow;
      merged[s]  = bus.In;

      if (bus.in_valid) begin
         case (state)
            IDLE: begin
               if (bus.in_sof) begin
                  shadow_nxt = first_word;
                  cnt_load   = 1'b1;
                  state_nxt  = COLLECT;
               end else begin
                  fe_nxt = 1'b1;
               end
            end

            COLLECT: begin
               if (bus.in_sof) begin
                  fe_nxt     = 1'b1;
                  shadow_nxt = first_word;
                  cnt_load   = 1'b1;
               end else begin
                  shadow_nxt = merged;
                  if (at_last) begin
`ifdef DEMUX_PARITY_EN
                     // S parks on LANES-1 while the parity beat is awaited.
                     state_nxt = PARITY;
`else
                     out_nxt   = merged;
                     ov_nxt    = 1'b1;
                     cnt_clr   = 1'b1;
                     state_nxt = IDLE;
`endif
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end
            end

`ifdef DEMUX_PARITY_EN
            PARITY: begin
               if (^{shadow, bus.In} == 1'b0) begin
                  out_nxt = shadow;
                  ov_nxt  = 1'b1;
               end else begin
                  pe_nxt = 1'b1;
               end
               if (bus.in_sof) begin
                  // The parity bit doubles as slot 0 of the next frame.
                  fe_nxt     = 1'b1;
                  shadow_nxt = first_word;
                  cnt_load   = 1'b1;
                  state_nxt  = COLLECT;
               end else begin
                  cnt_clr   = 1'b1;
                  state_nxt = IDLE;
               end
            end
`endif

            default: begin
               cnt_clr   = 1'b1;
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // NOTE: shadow is a plain register (not a RAM), so it is reset along with
   // the rest; a mid-frame reset therefore leaves no residue.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         shadow <= '0;
         out_q  <= '0;
         ov_q   <= 1'b0;
         fe_q   <= 1'b0;
`ifdef DEMUX_PARITY_EN
         pe_q   <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         shadow <= shadow_nxt;
         out_q  <= out_nxt;
         ov_q   <= ov_nxt;
         fe_q   <= fe_nxt;
`ifdef DEMUX_PARITY_EN
         pe_q   <= pe_nxt;
`endif
      end
   end

   assign bus.S         = s;
   assign bus.Out       = out_q;
   assign bus.out_valid = ov_q;
   assign bus.frame_err = fe_q;
`ifdef DEMUX_PARITY_EN
   assign bus.par_err   = pe_q;
`else
   assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1to4
// Self-checking bench for tdm_demux_1to4 (LANES = 4). Each table row is one
// clock: inputs driven at the falling edge, all outputs compared 1 ns after
// the following rising edge. Hand-written sequences cover gapped frames.
// Honours DEMUX_PARITY_EN with a separate parity-frame table.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1to4;

   typedef struct {
      logic       rst;
      logic       v;
      logic       sof;
      logic       b;
      logic [3:0] out;
      logic       ov;
      logic       fe;
      logic       pe;
      logic [1:0] s;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs[$];

   tdm_demux_1to4_if #(.LANES(4)) bus ();

   tdm_demux_1to4 #(.LANES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {Out,ov,fe,pe,S}=%b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic v, input logic sof, input logic b,
                      input logic [3:0] o, input logic ov, input logic fe,
                      input logic pe, input logic [1:0] s);
      vec_t x;
      x.rst = r;  x.v = v;   x.sof = sof; x.b = b;
      x.out = o;  x.ov = ov; x.fe = fe;   x.pe = pe; x.s = s;
      vecs.push_back(x);
   endtask

   task automatic drive(input logic r, input logic v, input logic sof, input logic b);
      @(negedge clk);
      rst          = r;
      bus.in_valid = v;
      bus.in_sof   = sof;
      bus.In       = b;
   endtask

   function automatic logic [8:0] observed();
      return {bus.Out, bus.out_valid, bus.frame_err, bus.par_err, bus.S};
   endfunction

   initial begin
      int ov_pulses;
      int fe_pulses;
      bus.In       = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;

`ifdef DEMUX_PARITY_EN
      //   rst v sof b   Out     ov fe pe S
      add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);   // reset state
      // 1111 + parity 0 -> good
      add(0, 1, 1, 1, 4'b0000, 0, 0, 0, 1);
      add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 2);
      add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 3);
      add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 3);   // last data beat: no commit yet
      add(0, 1, 0, 0, 4'b1111, 1, 0, 0, 0);
      // 0111 + parity 0 -> odd, Out holds 1111
      add(0, 1, 1, 1, 4'b1111, 0, 0, 0, 1);
      add(0, 1, 0, 1, 4'b1111, 0, 0, 0, 2);
      add(0, 1, 0, 1, 4'b1111, 0, 0, 0, 3);
      add(0, 1, 0, 0, 4'b1111, 0, 0, 0, 3);
      add(0, 1, 0, 0, 4'b1111, 0, 0, 1, 0);
      // 0111 + parity 1 -> good
      add(0, 1, 1, 1, 4'b1111, 0, 0, 0, 1);
      add(0, 1, 0, 1, 4'b1111, 0, 0, 0, 2);
      add(0, 1, 0, 1, 4'b1111, 0, 0, 0, 3);
      add(0, 1, 0, 0, 4'b1111, 0, 0, 0, 3);
      add(0, 1, 0, 1, 4'b0111, 1, 0, 0, 0);
      add(0, 0, 0, 0, 4'b0111, 0, 0, 0, 0);
      // stray data beat in IDLE
      add(0, 1, 0, 1, 4'b0111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 4'b0111, 0, 0, 0, 0);
`else
      //   rst v sof b   Out     ov fe pe S
      add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);   // reset state
      // 1,0,1,1 -> 1101
      add(0, 1, 1, 1, 4'b0000, 0, 0, 0, 1);
      add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 2);
      add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 3);
      add(0, 1, 0, 1, 4'b1101, 1, 0, 0, 0);
      add(0, 0, 0, 0, 4'b1101, 0, 0, 0, 0);
      // 1,1,0,1 with 3-cycle gaps -> 1011
      add(0, 1, 1, 1, 4'b1101, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 4'b1101, 0, 0, 0, 1);
      add(0, 1, 0, 1, 4'b1101, 0, 0, 0, 2);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 4'b1101, 0, 0, 0, 2);
      add(0, 1, 0, 0, 4'b1101, 0, 0, 0, 3);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'b1101, 0, 0, 0, 3);
      add(0, 1, 0, 1, 4'b1011, 1, 0, 0, 0);
      add(0, 0, 0, 0, 4'b1011, 0, 0, 0, 0);
      // data beat in IDLE without sof
      add(0, 1, 0, 1, 4'b1011, 0, 1, 0, 0);
      add(0, 0, 0, 0, 4'b1011, 0, 0, 0, 0);
      // sof after 2 beats restarts; new frame 0,0,0,1 -> 1000
      add(0, 1, 1, 1, 4'b1011, 0, 0, 0, 1);
      add(0, 1, 0, 1, 4'b1011, 0, 0, 0, 2);
      add(0, 1, 1, 0, 4'b1011, 0, 1, 0, 1);
      add(0, 1, 0, 0, 4'b1011, 0, 0, 0, 2);
      add(0, 1, 0, 0, 4'b1011, 0, 0, 0, 3);
      add(0, 1, 0, 1, 4'b1000, 1, 0, 0, 0);
      // back-to-back 0101 then 1010, no idle cycle
      add(0, 1, 1, 1, 4'b1000, 0, 0, 0, 1);
      add(0, 1, 0, 0, 4'b1000, 0, 0, 0, 2);
      add(0, 1, 0, 1, 4'b1000, 0, 0, 0, 3);
      add(0, 1, 0, 0, 4'b0101, 1, 0, 0, 0);
      add(0, 1, 1, 0, 4'b0101, 0, 0, 0, 1);
      add(0, 1, 0, 1, 4'b0101, 0, 0, 0, 2);
      add(0, 1, 0, 0, 4'b0101, 0, 0, 0, 3);
      add(0, 1, 0, 1, 4'b1010, 1, 0, 0, 0);
      // reset after 3 beats, with a beat on the reset edge
      add(0, 1, 1, 0, 4'b1010, 0, 0, 0, 1);
      add(0, 1, 0, 1, 4'b1010, 0, 0, 0, 2);
      add(0, 1, 0, 1, 4'b1010, 0, 0, 0, 3);
      add(1, 1, 0, 1, 4'b0000, 0, 0, 0, 0);
      add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
      // full frame 1111 afterwards
      add(0, 1, 1, 1, 4'b0000, 0, 0, 0, 1);
      add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 2);
      add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 3);
      add(0, 1, 0, 1, 4'b1111, 1, 0, 0, 0);
      add(0, 0, 0, 0, 4'b1111, 0, 0, 0, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].sof, vecs[i].b);
         @(posedge clk);
         #1;
         check($sformatf("row%0d", i), observed(),
               {vecs[i].out, vecs[i].ov, vecs[i].fe, vecs[i].pe, vecs[i].s});
      end

`ifndef DEMUX_PARITY_EN
      // Frame 1,1,0,0 with a one-cycle gap after each beat, observed over a
      // fixed window: exactly one out_valid, no frame_err, word 0011.
      ov_pulses = 0;
      fe_pulses = 0;
      for (int c = 0; c < 12; c++) begin
         if ((c % 2 == 0) && (c < 8))
            drive(1'b0, 1'b1, (c == 0), (c < 4));
         else
            drive(1'b0, 1'b0, 1'b0, 1'b0);
         @(posedge clk);
         #1;
         if (bus.out_valid) ov_pulses++;
         if (bus.frame_err) fe_pulses++;
      end
      check_int("gap_ov_pulses", ov_pulses, 1);
      check_int("gap_fe_pulses", fe_pulses, 0);
      check("gap_final", observed(), {4'b0011, 1'b0, 1'b0, 1'b0, 2'd0});
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1to4.md
# tdm_demux_1to4

Sequential 1-to-4 time-division demultiplexer: the receive end of a stream produced by a 4:1 MUX scanning its select 0..3. It accepts one serial bit per valid beat, steers the bit into the lane given by an internal slot counter, and presents the reassembled word on a held parallel output with a one-cycle strobe. It sits downstream of the MUX_4to1 datapath and converts its time-multiplexed output back into parallel form.

## Interface
- LANES, 4, number of lanes/slots per frame; power of two, 2..16
- SEL_W, $clog2(LANES), slot index width (derived; do not override)

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- In  in  1  serial data bit, qualified by in_valid
- in_valid  in  1  beat valid; when low, no state change (gaps allowed)
- in_sof  in  1  start of frame; meaningful only with in_valid
- S  out  SEL_W  slot index of the next expected beat
- Out  out  LANES  last complete word; Out[i] = bit received in slot i
- out_valid  out  1  one-cycle pulse; Out updated this cycle
- frame_err  out  1  one-cycle pulse on a framing violation
- par_err  out  1  one-cycle pulse on a parity mismatch (tied 0 without the macro)

## Operation
- States: IDLE (awaiting sof), COLLECT (slots 1..LANES-1), PARITY (macro only).
- IDLE, in_valid & in_sof: write In to shadow[0], S←1, go to COLLECT.
- IDLE, in_valid & !in_sof: drop the beat, pulse frame_err, stay in IDLE, S stays 0.
- COLLECT, in_valid & !in_sof: write shadow[S], S←S+1.
  - On S==LANES-1: without the macro, Out←shadow, pulse out_valid, S←0, go to IDLE. With the macro, go to PARITY.
- COLLECT, in_valid & in_sof: pulse frame_err, discard the partial word, restart: shadow[0]←In, S←1, stay in COLLECT.
- PARITY, in_valid: even parity. If ^{shadow,In}==0, Out←shadow and pulse out_valid. Otherwise Out holds and par_err pulses. S←0, go to IDLE. An in_sof on this beat also pulses frame_err and is treated as the start of a new frame.
- Out holds between frames. The shadow register is internal and never visible on Out mid-frame.
- Back-to-back frames: an sof on the beat immediately after the last beat is accepted with no bubble.

## Timing
- Reset values: Out=0, out_valid=0, frame_err=0, par_err=0, S=0, state IDLE, shadow=0.
- Latency: final beat sampled at edge N. Out, out_valid, par_err and frame_err change at edge N and hold for one cycle (registered outputs).
- Throughput: one frame per LANES beats (LANES+1 with the macro) at full in_valid.
- S advances at the same edge the beat is sampled.
- rst mid-frame: the partial word is discarded, Out clears to 0, and no out_valid is issued. rst has priority over all beats on the same edge.
- S wraps only through the last-slot/IDLE path; it never increments past LANES-1.

## Configuration
- DEMUX_PARITY_EN defined: frame = LANES data beats + 1 even-parity beat. The PARITY state is present, and par_err is active as described.
- Undefined: frame = LANES beats, no PARITY state, par_err is constant 0, and the word commits on the last data beat.

## Structure
- Shared package/include `tdm_demux_pkg` holds:
  - state encodings IDLE/COLLECT/PARITY
  - default LANES
  - SEL_W derivation
  - the parity-beat count constant (0 or 1 under the macro)
- One sub-module, `tdm_slot_counter`, owns S: load-1 on sof, increment, clear, and an at_last flag. The FSM and registers stay in the top level.

## Test plan
- Reset, then beats sof:1,0,1,1 (slot0..3) with the macro off: Out=4'b1101, a single out_valid pulse at edge 4, and S returns to 0.
- Beats 1,1,0,1 with in_valid gaps of 3 idle cycles between beats: Out=4'b1011, and no outputs change during gaps.
- Data beat in IDLE without sof: frame_err pulses once and Out is unchanged. Then an sof mid-frame after 2 beats: frame_err pulses and the new frame 0,0,0,1 yields Out=4'b1000.
- Two back-to-back frames 4'b0101 then 4'b1010 with no idle cycle: two out_valid pulses 4 cycles apart with the correct words.
- rst asserted after 3 beats of a frame: Out=0, S=0, no out_valid. The next full frame 4'b1111 commits normally.
- DEMUX_PARITY_EN: data 4'b0111 with parity 1 gives out_valid and Out=4'b0111. The same data with parity 0 gives par_err, and Out keeps its previous value.
